// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port controller:
// access lengths, FSM state encoding and bus widths.
package mem_ctrl_pkg;

  localparam int RamAddrBus = 32;
  localparam int RamDataBus = 8;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  typedef enum logic [2:0] {
    MemCtrlIdle  = 3'd0,
    MemCtrlIfRd  = 3'd1,
    MemCtrlMemRd = 3'd2,
    MemCtrlMemWr = 3'd3,
    MemCtrlDone  = 3'd4
  } mem_ctrl_state_e;

  // Number of byte beats for an access length; the unused code 11 is a word.
  function automatic logic [2:0] len_to_beats(input logic [1:0] len);
    logic [2:0] beats;
    case (len)
      LenByte: beats = 3'd1;
      LenHalf: beats = 3'd2;
      LenWord: beats = 3'd4;
      default: beats = 3'd4;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store traffic onto a byte-wide,
// one-cycle-latency RAM port, serialising accesses into byte beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req_i,
  input  logic [RamAddrBus-1:0] if_addr_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [RamAddrBus-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [RamDataBus-1:0] mem_din_i,
  output logic [RamDataBus-1:0] mem_dout_o,
  output logic [RamAddrBus-1:0] mem_a_o,
  output logic                  mem_wr_o,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  if_stall_req_o,
  output logic                  mem_stall_req_o
);

  mem_ctrl_state_e       state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            beats_q, beats_d;
  logic [RamAddrBus-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           result_q, result_d;
  logic                  is_if_q, is_if_d;

  logic [1:0]            byte_idx_s;
  logic                  if_abort_s;
  logic                  beat_s;
  logic                  done_s;

  assign byte_idx_s = cnt_q[1:0] - 2'd1;
  assign if_abort_s = !if_req_i || (if_addr_i != addr_q);

  // State register; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MemCtrlIdle;
      cnt_q    <= 3'd0;
      beats_q  <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      result_q <= 32'h0;
      is_if_q  <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      is_if_q  <= is_if_d;
    end else begin
      state_q  <= state_q;
      cnt_q    <= cnt_q;
      beats_q  <= beats_q;
      addr_q   <= addr_q;
      wdata_q  <= wdata_q;
      result_q <= result_q;
      is_if_q  <= is_if_q;
    end
  end

  // Next-state logic: arbitration, beat sequencing and byte assembly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    is_if_d  = is_if_q;
    case (state_q)
      MemCtrlIdle: begin
        cnt_d = 3'd0;
        if (mem_req_i) begin
          addr_d   = mem_addr_i;
          beats_d  = len_to_beats(mem_len_i);
          wdata_d  = mem_wdata_i;
          result_d = 32'h0;
          is_if_d  = 1'b0;
          state_d  = mem_we_i ? MemCtrlMemWr : MemCtrlMemRd;
        end else if (if_req_i) begin
          addr_d   = if_addr_i;
          beats_d  = 3'd4;
          wdata_d  = 32'h0;
          result_d = 32'h0;
          is_if_d  = 1'b1;
          state_d  = MemCtrlIfRd;
        end else begin
          state_d = MemCtrlIdle;
        end
      end
      MemCtrlIfRd, MemCtrlMemRd: begin
        if ((state_q == MemCtrlIfRd) && if_abort_s) begin
          state_d = MemCtrlIdle;
          cnt_d   = 3'd0;
        end else begin
          // Byte for the previous beat's address arrives this cycle.
          if (cnt_q != 3'd0) begin
            result_d[{byte_idx_s, 3'b000} +: 8] = mem_din_i;
          end else begin
            result_d = result_q;
          end
          if (cnt_q == beats_q) begin
            state_d = MemCtrlDone;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      MemCtrlMemWr: begin
        if (cnt_q == (beats_q - 3'd1)) begin
          state_d = MemCtrlDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      MemCtrlDone: begin
        state_d = MemCtrlIdle;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = MemCtrlIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output decode from registered state; writes and done are gated by rdy.
  always_comb begin
    beat_s = 1'b0;
    case (state_q)
      MemCtrlIfRd, MemCtrlMemRd: beat_s = (cnt_q < beats_q);
      MemCtrlMemWr:              beat_s = 1'b1;
      default:                   beat_s = 1'b0;
    endcase
  end

  assign done_s          = (state_q == MemCtrlDone) && rdy;
  assign mem_a_o         = beat_s ? (addr_q + {29'd0, cnt_q}) : 32'h0;
  assign mem_dout_o      = (state_q == MemCtrlMemWr) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign mem_wr_o        = (state_q == MemCtrlMemWr) && rdy;
  assign if_done_o       = done_s && is_if_q;
  assign mem_done_o      = done_s && !is_if_q;
  assign if_data_o       = if_done_o ? result_q : 32'h0;
  assign mem_rdata_o     = mem_done_o ? result_q : 32'h0;
  assign if_stall_req_o  = if_req_i && !if_done_o;
  assign mem_stall_req_o = mem_req_i && !mem_done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  din_q = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [31:0] if_data;
  logic        if_done;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        if_stall;
  logic        mem_stall;

  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;
  logic [7:0]  ram [0:65535] = '{default: 8'h00};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_din_i(din_q),
    .mem_dout_o(mem_dout), .mem_a_o(mem_a), .mem_wr_o(mem_wr),
    .if_data_o(if_data), .if_done_o(if_done),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .if_stall_req_o(if_stall), .mem_stall_req_o(mem_stall)
  );

  // RAM model: 64 KiB window, one-cycle read latency, frozen with the global rdy.
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (rdy) begin
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
      din_q <= ram[mem_a[15:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    cyc();
    pre_we   = 1'b0;
  endtask

  task automatic set_mem(input logic we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_len   = len;
    mem_addr  = a;
    mem_wdata = wd;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    cyc();
    preload(16'h1000, 8'h13);
    preload(16'h2000, 8'h78);
    preload(16'h2001, 8'h56);
    preload(16'h2002, 8'hAA);
    preload(16'h2003, 8'hBB);
    preload(16'hFFFF, 8'h11);
    preload(16'h0000, 8'h22);
    #1;
    check("rst_a", mem_a, 32'h0);
    check("rst_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_dout", {24'd0, mem_dout}, 32'h0);
    check("rst_done", {30'd0, if_done, mem_done}, 32'h0);
    check("rst_stall", {30'd0, if_stall, mem_stall}, 32'h0);
    cyc();
    rst = 1'b0;

    // Instruction fetch of a word at 0x1000
    cyc();
    if_req = 1'b1; if_addr = 32'h1000;
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin cyc(); #1; end
      check("if_a", mem_a, (c >= 1 && c <= 4) ? 32'h1000 + 32'(c - 1) : 32'h0);
      check("if_done", {31'd0, if_done}, (c == 6) ? 32'h1 : 32'h0);
      check("if_stall", {31'd0, if_stall}, (c <= 5) ? 32'h1 : 32'h0);
      if (c == 6) check("if_data", if_data, 32'h00000013);
    end
    cyc();
    if_req = 1'b0;
    #1;
    check("if_idle_a", mem_a, 32'h0);

    // MEM half load wins over a simultaneous fetch
    cyc();
    if_req = 1'b1; if_addr = 32'h1000;
    set_mem(1'b0, 2'b01, 32'h2002, 32'h0);
    #1;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) begin cyc(); if (c == 5) mem_req = 1'b0; #1; end
      check("arb_a", mem_a, (c == 1) ? 32'h2002 : (c == 2) ? 32'h2003 :
                            (c >= 6 && c <= 9) ? 32'h1000 + 32'(c - 6) : 32'h0);
      check("arb_mdone", {31'd0, mem_done}, (c == 4) ? 32'h1 : 32'h0);
      check("arb_idone", {31'd0, if_done}, (c == 11) ? 32'h1 : 32'h0);
      check("arb_mstall", {31'd0, mem_stall}, (c <= 3) ? 32'h1 : 32'h0);
      if (c == 4) check("arb_rdata", mem_rdata, 32'h0000BBAA);
      if (c == 11) check("arb_idata", if_data, 32'h00000013);
    end
    cyc();
    if_req = 1'b0;

    // Word store
    cyc();
    set_mem(1'b1, 2'b10, 32'h3000, 32'hDEADBEEF);
    #1;
    for (int c = 0; c <= 5; c++) begin
      logic [31:0] wv;
      wv = 32'hDEADBEEF;
      if (c > 0) begin cyc(); #1; end
      check("st_wr", {31'd0, mem_wr}, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
      check("st_a", mem_a, (c >= 1 && c <= 4) ? 32'h3000 + 32'(c - 1) : 32'h0);
      if (c >= 1 && c <= 4) check("st_dout", {24'd0, mem_dout}, {24'd0, wv[8*(c-1) +: 8]});
      check("st_done", {31'd0, mem_done}, (c == 5) ? 32'h1 : 32'h0);
    end
    cyc();
    mem_req = 1'b0;
    #1;
    check("st_ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'hDEADBEEF);

    // Fetch aborted by an address change, then refetch
    cyc();
    if_req = 1'b1; if_addr = 32'h1000;
    #1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) begin cyc(); if (c == 2) if_addr = 32'h2000; #1; end
      check("ab_a", mem_a, (c == 1) ? 32'h1000 : (c == 2) ? 32'h1001 :
                           (c >= 4 && c <= 7) ? 32'h2000 + 32'(c - 4) : 32'h0);
      check("ab_done", {31'd0, if_done}, (c == 9) ? 32'h1 : 32'h0);
      if (c == 9) check("ab_data", if_data, 32'hBBAA5678);
    end
    cyc();
    if_req = 1'b0;

    // Half load wrapping past 0xFFFFFFFF
    cyc();
    set_mem(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0);
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin cyc(); #1; end
      check("wr_a", mem_a, (c == 1) ? 32'hFFFFFFFF : 32'h0);
      check("wr_done", {31'd0, mem_done}, (c == 4) ? 32'h1 : 32'h0);
      if (c == 4) check("wr_rdata", mem_rdata, 32'h00002211);
    end
    cyc();
    mem_req = 1'b0;

    // Byte load with rdy low in cycles 2-4
    cyc();
    set_mem(1'b0, 2'b00, 32'h1000, 32'h0);
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin cyc(); rdy = !(c >= 2 && c <= 4); #1; end
      check("rdy_a", mem_a, (c == 1) ? 32'h1000 : 32'h0);
      check("rdy_done", {31'd0, mem_done}, (c == 6) ? 32'h1 : 32'h0);
      if (c == 6) check("rdy_rdata", mem_rdata, 32'h00000013);
    end
    cyc();
    mem_req = 1'b0;

    // Byte store with rdy low on the beat and on the done cycle
    cyc();
    set_mem(1'b1, 2'b00, 32'h3010, 32'h0000005A);
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin cyc(); rdy = !(c == 1 || c == 3); #1; end
      check("sr_a", mem_a, (c == 1 || c == 2) ? 32'h3010 : 32'h0);
      check("sr_wr", {31'd0, mem_wr}, (c == 2) ? 32'h1 : 32'h0);
      check("sr_done", {31'd0, mem_done}, (c == 4) ? 32'h1 : 32'h0);
      check("sr_stall", {31'd0, mem_stall}, (c <= 3) ? 32'h1 : 32'h0);
    end
    cyc();
    mem_req = 1'b0;
    #1;
    check("sr_ram", {24'd0, ram[16'h3010]}, 32'h0000005A);

    // Reset during cycle 2 of a word store
    cyc();
    set_mem(1'b1, 2'b10, 32'h3020, 32'h11223344);
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        cyc();
        if (c == 2) rst = 1'b1;
        if (c == 3) begin rst = 1'b0; mem_req = 1'b0; end
        #1;
      end
      if (c == 2) check("rs_a2", mem_a, 32'h3021);
      if (c >= 3) begin
        check("rs_a", mem_a, 32'h0);
        check("rs_wr", {31'd0, mem_wr}, 32'h0);
        check("rs_dout", {24'd0, mem_dout}, 32'h0);
        check("rs_done", {31'd0, mem_done}, 32'h0);
        check("rs_rdata", mem_rdata, 32'h0);
        check("rs_stall", {31'd0, mem_stall}, 32'h0);
      end
    end
    check("rs_ram", {ram[16'h3023], ram[16'h3022], ram[16'h3021], ram[16'h3020]}, 32'h00003344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Arbitrates the CPU's instruction-fetch and load/store traffic onto the single byte-wide, one-cycle-latency RAM port. Serialises 1/2/4-byte accesses into byte beats and assembles little-endian 32-bit results. Produces `if_stall_req_o` and `mem_stall_req_o`, which feed the pipeline stall controller directly. Sits between the IF/MEM stages and the top-level RAM interface.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rdy`  in  1  global ready; low freezes all state
- `if_req_i`  in  1  IF requests a 4-byte instruction read
- `if_addr_i`  in  32  instruction byte address
- `mem_req_i`  in  1  MEM requests a data access
- `mem_we_i`  in  1  1 = store, 0 = load
- `mem_len_i`  in  2  `LenByte`=00, `LenHalf`=01, `LenWord`=10 (11 unused, treated as word)
- `mem_addr_i`  in  32  data byte address
- `mem_wdata_i`  in  32  store data, low bytes used
- `mem_din_i`  in  8  RAM read byte, valid one cycle after its address
- `mem_dout_o`  out  8  RAM write byte
- `mem_a_o`  out  32  RAM address
- `mem_wr_o`  out  1  RAM write enable
- `if_data_o`  out  32  fetched instruction, valid while `if_done_o`
- `if_done_o`  out  1  one-cycle pulse, fetch complete
- `mem_rdata_o`  out  32  load data, zero-extended, valid while `mem_done_o`
- `mem_done_o`  out  1  one-cycle pulse, data access complete
- `if_stall_req_o`  out  1  `if_req_i && !if_done_o` (combinational)
- `mem_stall_req_o`  out  1  `mem_req_i && !mem_done_o` (combinational)

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE. 3-bit beat counter, N = 1/2/4 bytes.
- IDLE:
  - `mem_req_i` wins over `if_req_i` when both are high.
  - The winner's address, len, we and wdata are latched. The FSM moves to MEM_WR, MEM_RD or IF_RD.
- MEM_WR:
  - Beat i drives `mem_a_o`=addr+i, `mem_dout_o`=wdata[8i+7:8i], `mem_wr_o`=1.
  - After beat N-1, go to DONE.
- MEM_RD / IF_RD:
  - Beat i drives `mem_a_o`=addr+i for i=0..N-1.
  - Byte i arrives on `mem_din_i` the following cycle and goes into result[8i+7:8i].
  - The cycle after the last address drive captures byte N-1, then the FSM goes to DONE.
- DONE:
  - Asserts the matching `*_done_o` with the assembled data.
  - Requests seen in this cycle are ignored. Next state is IDLE.
  - A request still high in the following IDLE cycle is treated as a new access.
- IF abort: in IF_RD, if `if_req_i` is low or `if_addr_i` differs from the latched address, go to IDLE next cycle. No `if_done_o` is produced.
- MEM accesses never abort.
- Idle outputs: when not driving a beat, `mem_a_o`=0, `mem_dout_o`=0, `mem_wr_o`=0.
- Address wrap: 32-bit addition wraps at 0xFFFFFFFF.

## Timing
- Request first visible in cycle 0 (IDLE). Beat i drives in cycle 1+i.
- Read of N bytes: last byte on `mem_din_i` in cycle N+1; `*_done_o` in cycle N+2. Word read completes in 6 cycles.
- Write of N bytes: `*_done_o` in cycle N+1. Byte write completes in 2 cycles.
- Earliest next acceptance is the cycle after DONE.
- `rdy`=0:
  - Every register holds, including state, counter and result.
  - `mem_wr_o` is forced to 0.
  - `*_done_o` is held off and reasserts when `rdy` returns.
- Reset (any cycle, including mid-write): state IDLE; all outputs and registers 0 next cycle.
  - Bytes already written remain in RAM. Stall outputs then follow the requests.

## Structure
- Shared `defines.v` gets:
  - `LenByte`, `LenHalf`, `LenWord`
  - FSM state encodings `MemCtrlIdle` … `MemCtrlDone` (3 bits)
  - `RamAddrBus`, `RamDataBus` width macros
- Single flat module; no sub-module is warranted.

## Test plan
- IF word read at 0x1000, RAM bytes 13 00 00 00 -> `mem_a_o` 0x1000..0x1003 in cycles 1-4; `if_done_o` in cycle 6 with `if_data_o`=0x00000013; `if_stall_req_o` high in cycles 0-5.
- `if_req_i` and `mem_req_i` (load half, 0x2002) together -> MEM served first; `mem_rdata_o`=0x0000BBAA in cycle 4; IF fetch starts in cycle 5.
- Store word 0xDEADBEEF to 0x3000 -> cycles 1-4 `mem_wr_o`=1 with bytes EF BE AD DE; `mem_done_o` in cycle 5.
- IF read at 0x1000, `if_addr_i` changes to 0x2000 in cycle 2 -> IDLE in cycle 3, no `if_done_o`; new fetch at 0x2000 proceeds normally.
- Load byte with `rdy` low in cycles 2-4 -> `mem_a_o`/state frozen; `mem_done_o` delayed by exactly 3 cycles.
- `rst` in cycle 2 of a word store -> all outputs 0 next cycle; no `mem_done_o`; `mem_wr_o`=0 afterwards.
